frame_buffer_ram: RTL and testbench

FRAME_BUFFER_RAM -- requirements
Module: frame_buffer_ram

---
 rtl/frame_buffer_ram.sv | 117 +++++++++++
 tb/tb_frame_buffer_ram.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_ram.sv
// rtl/frame_buffer_ram.sv - single-clock frame buffer with registered read port and full-frame clear sweep
// One shared write port serves user writes and the clear sweep; the sweep owns it while busy.
module frame_buffer_ram #(
    parameter int                DATA_W    = 5,
    parameter int                WIDTH_PX  = 640,
    parameter int                HEIGHT_PX = 480,
    parameter int                ADDR_W    = 19,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [DATA_W-1:0] data_In,
    input  logic              re,
    input  logic [ADDR_W-1:0] read_address,
    output logic [DATA_W-1:0] data_Out,
    output logic              rd_valid,
    input  logic              clear_start,
    output logic              busy,
    output logic              clear_done
);

    localparam int                DEPTH     = WIDTH_PX * HEIGHT_PX;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            S_IDLE: begin
                if (clear_start) begin
                    state_nxt = S_CLEAR;
                    ptr_nxt   = '0;
                end
            end
            S_CLEAR: begin
                if (ptr == LAST_ADDR) begin
                    state_nxt = S_DONE;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy       = (state == S_CLEAR);
    assign clear_done = (state == S_DONE);

    // User writes arriving while the sweep runs are dropped, not deferred.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = write_address;
        mem_wdata = data_In;
        if (busy) begin
            mem_we    = 1'b1;
            mem_waddr = ptr;
            mem_wdata = CLEAR_VAL;
        end else if (we && (write_address <= LAST_ADDR)) begin
            mem_we = 1'b1;
        end
    end

    // Storage is never reset so it stays mappable onto block RAM.
    always_ff @(posedge Clk) begin
        if (mem_we && !Reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read-first: the array update above lands after this sample is taken.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            data_Out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= re;
            if (re) begin
                data_Out <= (read_address <= LAST_ADDR) ? mem[read_address] : '0;
            end
        end
    end

endmodule

// File: tb/tb_frame_buffer_ram.sv
// tb/tb_frame_buffer_ram.sv - directed scoreboard bench for frame_buffer_ram (3x2 frame)
module tb_frame_buffer_ram;

    logic       Clk;
    logic       Reset;
    logic       we;
    logic [2:0] write_address;
    logic [4:0] data_In;
    logic       re;
    logic [2:0] read_address;
    logic [4:0] data_Out;
    logic       rd_valid;
    logic       clear_start;
    logic       busy;
    logic       clear_done;

    frame_buffer_ram #(
        .DATA_W   (5),
        .WIDTH_PX (3),
        .HEIGHT_PX(2),
        .ADDR_W   (3),
        .CLEAR_VAL(5'h00)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .we           (we),
        .write_address(write_address),
        .data_In      (data_In),
        .re           (re),
        .read_address (read_address),
        .data_Out     (data_Out),
        .rd_valid     (rd_valid),
        .clear_start  (clear_start),
        .busy         (busy),
        .clear_done   (clear_done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int         passed;
    int         total;
    logic [4:0] model [8];
    logic [4:0] rd_q [$];
    logic [4:0] last_out;
    logic       wr_allowed;

    task automatic check_bit(input string tag, input logic obs, input logic exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    endtask

    task automatic check_word(input string tag, input logic [4:0] obs, input logic [4:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    endtask

    // One clock: queue the expected read result, apply accepted writes to the model, then compare.
    task automatic tick();
        logic rv_exp;
        if (re) rd_q.push_back((read_address < 3'd6) ? model[read_address] : 5'h00);
        rv_exp = re;
        @(posedge Clk);
        if (we && wr_allowed && (write_address < 3'd6)) model[write_address] = data_In;
        #1;
        check_bit("rd_valid", rd_valid, rv_exp);
        if (rv_exp && rd_q.size() > 0) last_out = rd_q.pop_front();
        check_word("data_Out", data_Out, last_out);
    endtask

    task automatic write_word(input logic [2:0] a, input logic [4:0] d);
        we = 1'b1; write_address = a; data_In = d;
        tick();
        we = 1'b0;
    endtask

    task automatic read_word(input logic [2:0] a);
        re = 1'b1; read_address = a;
        tick();
        re = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int done_at;
        passed = 0; total = 0; last_out = 5'h00; wr_allowed = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = 5'h00;
        Reset = 1'b1; we = 1'b0; write_address = '0; data_In = '0;
        re = 1'b0; read_address = '0; clear_start = 1'b0;

        #1;
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_done", clear_done, 1'b0);
        check_bit("reset_rv", rd_valid, 1'b0);
        check_word("reset_dout", data_Out, 5'h00);
        @(posedge Clk); #1;
        Reset = 1'b0;

        // Basic write then read, then hold with re low
        write_word(3'd3, 5'h1A);
        read_word(3'd3);
        check_word("s1_read", data_Out, 5'h1A);
        tick();
        check_word("s1_hold", data_Out, 5'h1A);

        // Same-address read and write at one edge returns old data
        write_word(3'd2, 5'h1F);
        we = 1'b1; write_address = 3'd2; data_In = 5'h05;
        re = 1'b1; read_address = 3'd2;
        tick();
        we = 1'b0; re = 1'b0;
        check_word("s2_old", data_Out, 5'h1F);
        read_word(3'd2);
        check_word("s2_new", data_Out, 5'h05);

        // Full clear sweep with a dropped write late in the sweep
        for (int i = 0; i < 6; i++) write_word(3'(i), 5'h1F);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        wr_allowed = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_bit("s3_busy", busy, 1'b1);
            check_bit("s3_nodone", clear_done, 1'b0);
            if (i == 4) begin
                we = 1'b1; write_address = 3'd1; data_In = 5'h11;
            end
            tick();
            we = 1'b0;
        end
        check_bit("s3_busy_end", busy, 1'b0);
        check_bit("s3_done", clear_done, 1'b1);
        tick();
        check_bit("s3_done_once", clear_done, 1'b0);
        wr_allowed = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = 5'h00;
        for (int i = 0; i < 6; i++) read_word(3'(i));

        // Out-of-range write is dropped, out-of-range read yields zero
        write_word(3'd0, 5'h1F);
        write_word(3'd7, 5'h0F);
        read_word(3'd0);
        read_word(3'd7);
        check_word("s4_oor_read", data_Out, 5'h00);
        for (int i = 1; i < 6; i++) read_word(3'(i));

        // Reset mid-sweep aborts the sweep and blocks writes
        for (int i = 0; i < 6; i++) write_word(3'(i), 5'h1F);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        tick();
        tick();
        read_word(3'd5);
        check_bit("s5_busy_pre", busy, 1'b1);
        check_word("s5_dout_pre", data_Out, 5'h1F);
        Reset = 1'b1;
        #2;
        check_bit("s5_async_busy", busy, 1'b0);
        check_bit("s5_async_done", clear_done, 1'b0);
        check_bit("s5_async_rv", rd_valid, 1'b0);
        check_word("s5_async_dout", data_Out, 5'h00);
        we = 1'b1; write_address = 3'd4; data_In = 5'h00;
        @(posedge Clk); #1;
        check_bit("s5_hold_busy", busy, 1'b0);
        Reset = 1'b0; we = 1'b0;
        last_out = 5'h00;
        for (int i = 0; i < 3; i++) model[i] = 5'h00;
        for (int i = 0; i < 6; i++) read_word(3'(i));

        // Second clear_start during a sweep is ignored
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (clear_done === 1'b1) begin
                done_cnt++;
                done_at = i;
            end
            clear_start = (i == 2);
            tick();
        end
        clear_start = 1'b0;
        check_int("s6_busy_cycles", busy_cnt, 6);
        check_int("s6_done_count", done_cnt, 1);
        check_int("s6_done_at", done_at, 6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
